prio_enc32to5: RTL and testbench
================================

Name: prio_enc32to5

Overview:
- Sequential counterpart of the team's 5-to-32 decoder: collects up to 32 one-hot request lines into a pending register.
- Presents the lowest-index pending request as a 5-bit code under a valid/ready handshake.
- Clears each request once the consumer accepts its code.
- Sits between event sources (e.g. decoded select/IRQ lines) and a single 5-bit consumer.

Parameters:
- N, 32, number of request lines (power of two, 2..32).
- W, 5, code width; must equal $clog2(N). Elaboration-time check.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- e  input  1  request enable; when 0, new requests are not latched.
- req  input  N  request lines, sampled each rising edge, level or pulse.
- code  output  W  index of the granted request, registered.
- valid  output  1  code holds a pending request, registered.
- ready  input  1  consumer accepts code this cycle when valid=1.
- drop  output  1  one-cycle pulse: a request hit a bit already pending.
- pend_any  output  1  registered OR of the pending register.

Behaviour:
- Reset: the asynchronous assertion of rst_n=0 immediately clears pending, code, valid, drop, pend_any and forces state IDLE. Release is synchronous to clk.
- Reset mid-transaction discards all pending requests and any offered code. No replay.
- Pending update, every edge:
  - pending <= (pending & ~clr) | (e ? req : 0).
  - clr is the one-hot of code when valid & ready, else 0.
  - A new request on the bit being cleared in the same cycle wins: the bit stays set.
- drop: asserted for one cycle when e=1 and req[i]=1 with pending[i]=1 and that bit is not being cleared this cycle.
- State machine, 2 states:
  - IDLE: valid=0. If pending!=0 at the edge, load code = lowest set index of pending, set valid=1 and go to OFFER. Otherwise stay in IDLE.
  - OFFER: valid=1. code and valid are held stable while ready=0. On valid&ready: valid<=0, go to IDLE; the matching pending bit clears on the same edge.
- Priority is fixed: index 0 is highest. A lower-index request arriving during OFFER does not preempt the offered code.
- Latency:
  - req sampled at edge k sets pending at edge k.
  - valid rises at edge k+1 when in IDLE.
  - Minimum grant spacing is 2 cycles (one IDLE cycle between grants).
- e=0: req is ignored and drop is held at 0. Already-pending requests are still offered and cleared normally.
- pend_any is registered from pending_next, so it equals |pending after each edge.
- Wrap/boundary cases:
  - All 32 bits pending: codes are served in order 0..31.
  - Only bit 31 pending: code=5'd31.
  - pending=0 in IDLE: valid stays 0, and code holds its last value (don't-care for consumers).
- ready while valid=0 has no effect.

Decomposition:
- Shared package prio_enc_pkg: state enum (IDLE, OFFER) and constants N_DEF=32, W_DEF=5.
- One natural sub-module: lsb_first_enc, a combinational lowest-set-bit finder (N -> W plus any).
- Everything else (pending register, FSM, drop) stays in the top module.

Test Plan:
- Reset and quiet bus: rst_n=0 for 3 cycles then 1, req=0 -> valid=0, code=0, pend_any=0 for 10 cycles. Asserting rst_n mid-OFFER drops valid immediately (before any clock edge).
- Single request: e=1, req=32'h0000_0020 for 1 cycle, ready=1 -> valid=1 with code=5'd5 one edge later; accepted; pend_any=0 after the next edge.
- Priority and stall: req=32'h8000_0001 | 32'h0000_0100 in one cycle, ready=0 for 5 cycles then 1 -> code=0 held stable during the stall, then 8, then 31, each separated by one IDLE cycle.
- Drop and collision:
  - req[3] pulses twice while bit 3 is pending and not yet accepted -> drop=1 for exactly one cycle.
  - req[3] in the same cycle as acceptance of code 3 -> drop=0, and code=3 is offered again after the IDLE cycle.
- Enable gating: e=0 with req=32'hFFFF_FFFF -> pending stays 0, valid=0, drop=0. Then e=1 for one cycle -> 32 grants, codes 0..31 in order.
- Sweep: one-hot req=1<<i for i=0..31, one request at a time, ready=1 -> code==i for every i; this is the encoder/decoder round-trip against dec5to32.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared state encoding and default sizes for the priority encoder.
package prio_enc_pkg;
  typedef enum logic {IDLE, OFFER} state_t;
  localparam int N_DEF = 32;
  localparam int W_DEF = 5;
endpackage

// File: rtl/lsb_first_enc.sv
// lsb_first_enc: combinational finder of the lowest set bit index.
module lsb_first_enc #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (bits[i]) idx = W'(i);
  end
  assign any = |bits;
endmodule

// File: rtl/prio_enc32to5.sv
// prio_enc32to5: latches one-hot requests and offers the lowest pending index under valid/ready.
module prio_enc32to5
  import prio_enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic         drop,
  output logic         pend_any
);
  state_t       state;
  logic [N-1:0] pending, clr, nreq, pending_next;
  logic [W-1:0] low;
  logic         any;
  if (W != $clog2(N) || N < 2 || N > 32 || (1 << W) != N) begin : g_bad_params
    $error("prio_enc32to5: N must be a power of two in 2..32 and W must equal $clog2(N)");
  end
  assign valid = state == OFFER;
  assign clr = (valid && ready) ? N'(1) << code : '0;
  assign nreq = e ? req : '0;
  // a fresh request on the bit being cleared re-sets it
  assign pending_next = (pending & ~clr) | nreq;
  lsb_first_enc #(.N(N), .W(W)) u_enc (.bits(pending), .idx(low), .any(any));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending  <= '0;
      pend_any <= 1'b0;
      drop     <= 1'b0;
      code     <= '0;
      state    <= IDLE;
    end else begin
      pending  <= pending_next;
      pend_any <= |pending_next;
      drop     <= |(nreq & pending & ~clr);
      if (state == IDLE && any) begin
        code  <= low;
        state <= OFFER;
      end else if (state == OFFER && ready) state <= IDLE;
    end
endmodule

// File: tb/tb_prio_enc32to5.sv
// tb_prio_enc32to5: randomized and directed checks against a bit-array reference model.
module tb_prio_enc32to5;
  logic        clk = 0, rst_n = 0, e = 0, ready = 0;
  logic [31:0] req = '0;
  logic [4:0]  code;
  logic        valid, drop, pend_any;
  int n_cmp = 0, n_bad = 0;
  int grants[$];
  bit pend[32];
  bit m_valid, m_drop;
  int m_code;

  always #5 clk = ~clk;

  prio_enc32to5 dut (
    .clk(clk), .rst_n(rst_n), .e(e), .req(req), .code(code),
    .valid(valid), .ready(ready), .drop(drop), .pend_any(pend_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_any();
    bit a = 0;
    for (int i = 0; i < 32; i++) a |= pend[i];
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_valid = 0;
    m_drop = 0;
    m_code = 0;
  endtask

  // one clock edge of the behaviour, using the inputs present before that edge
  task automatic model_step();
    int cleared = (m_valid && ready) ? m_code : -1;
    int first = -1;
    for (int i = 0; i < 32; i++) if (pend[i] && first < 0) first = i;
    m_drop = 0;
    for (int i = 0; i < 32; i++) if (e && req[i] && pend[i] && i != cleared) m_drop = 1;
    if (cleared >= 0) pend[cleared] = 0;
    for (int i = 0; i < 32; i++) if (e && req[i]) pend[i] = 1;
    if (m_valid) begin
      if (ready) m_valid = 0;
    end else if (first >= 0) begin
      m_valid = 1;
      m_code = first;
    end
  endtask

  task automatic cycle(input logic ee, input logic [31:0] rr, input logic rd);
    bit acc;
    int acc_code;
    e = ee;
    req = rr;
    ready = rd;
    acc = valid && rd;
    acc_code = int'(code);
    @(posedge clk);
    if (acc) grants.push_back(acc_code);
    model_step();
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    check("code", 32'(code), 32'(m_code));
    check("drop", 32'(drop), 32'(m_drop));
    check("pend_any", 32'(pend_any), 32'(m_any()));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_code", 32'(code), 0);
    check("rst_pend_any", 32'(pend_any), 0);
    rst_n = 1;
    repeat (10) cycle(1, 0, 0);

    cycle(1, 32'h10, 0);
    cycle(1, 0, 0);
    check("offer_before_reset", 32'(valid), 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", 32'(valid), 0);
    check("async_rst_pend_any", 32'(pend_any), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    cycle(1, 0, 1);
    check("no_replay", 32'(valid), 0);

    grants.delete();
    cycle(1, 32'h20, 1);
    cycle(1, 0, 1);
    check("single_valid", 32'(valid), 1);
    check("single_code", 32'(code), 5);
    cycle(1, 0, 1);
    check("single_pend_any", 32'(pend_any), 0);
    check("single_grants", grants.size(), 1);

    grants.delete();
    cycle(1, 32'h8000_0101, 0);
    repeat (5) begin
      cycle(1, 0, 0);
      check("stall_code", 32'(code), 0);
    end
    repeat (8) cycle(1, 0, 1);
    check("prio_count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("prio_g0", grants[0], 0);
      check("prio_g1", grants[1], 8);
      check("prio_g2", grants[2], 31);
    end

    cycle(1, 32'h8, 0);
    cycle(1, 32'h8, 0);
    check("drop_hit", 32'(drop), 1);
    cycle(1, 0, 0);
    check("drop_pulse", 32'(drop), 0);
    check("bit3_offered", 32'(code), 3);
    cycle(1, 32'h8, 1);
    check("collide_nodrop", 32'(drop), 0);
    check("collide_pending", 32'(pend_any), 1);
    cycle(1, 0, 0);
    check("reoffer_valid", 32'(valid), 1);
    check("reoffer_code", 32'(code), 3);
    repeat (4) cycle(1, 0, 1);

    repeat (3) cycle(0, 32'hFFFF_FFFF, 1);
    check("gate_pend_any", 32'(pend_any), 0);
    check("gate_drop", 32'(drop), 0);
    check("gate_valid", 32'(valid), 0);
    grants.delete();
    cycle(1, 32'hFFFF_FFFF, 1);
    repeat (70) cycle(1, 0, 1);
    check("all_count", grants.size(), 32);
    for (int i = 0; i < 32 && i < grants.size(); i++) check("all_order", grants[i], i);

    for (int i = 0; i < 32; i++) begin
      grants.delete();
      cycle(1, 32'(1) << i, 1);
      repeat (3) cycle(1, 0, 1);
      check("sweep_count", grants.size(), 1);
      if (grants.size() > 0) check("sweep_code", grants[0], i);
    end

    repeat (600) cycle($urandom_range(0, 3) != 0, $urandom & $urandom & $urandom, 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
